id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of npc/register-data/sign-extend fields.
REQ-002 SHALL have parameter REG_W, default 5, width of register-number fields.
REQ-003 SHALL have parameter CNT_W, default 16, width of bubble counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-005 SHALL have ports: in_valid input 1 upstream entry valid; in_ready output 1 stage can accept; flush input 1 kill held entries.
REQ-006 SHALL have inputs ctlwb_in 2, ctlm_in 3, ctlex_in 4 (bit3 regdst, bits2:1 aluop, bit0 alusrc), npc/readdat1/readdat2/signext_in DATA_W each, instr_2016/instr_1511 REG_W each.
REQ-007 SHALL have out_valid output 1 entry present; out_ready input 1 EX consumes.
REQ-008 SHALL have outputs wb_ctlout 2, m_ctlout 3, regdst 1, aluop 2, alusrc 1, npcout/rdata1out/rdata2out/s_extendout DATA_W, instrout_2016/instrout_1511 REG_W, bubble_cnt CNT_W.

Function
REQ-009 SHALL accept an entry on a rising clk when in_valid=1 and in_ready=1; latency input-to-output 1 cycle.
REQ-010 SHALL release the output entry on a rising clk when out_valid=1 and out_ready=1.
REQ-011 SHALL (skid disabled) drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-012 SHALL, on accept and release in the same cycle, load the new entry with out_valid remaining 1.
REQ-013 SHALL, on release without accept, clear out_valid to 0.
REQ-014 SHALL, while out_valid=1 and out_ready=0, hold all outputs stable.
REQ-015 SHALL drive wb_ctlout, m_ctlout, regdst, aluop, alusrc to 0 whenever out_valid=0 (bubble = nop); data/register fields hold last loaded value.
REQ-016 SHALL, on a rising clk with flush=1, clear out_valid and any stored entry, accept nothing (in_ready=0), regardless of in_valid/out_ready.
REQ-017 SHALL increment bubble_cnt by 1 per flush cycle in which at least one valid entry is killed; saturate at all-ones, no wrap.
REQ-018 SHALL keep bubble_cnt unchanged for flush when the stage is empty.

Reset
REQ-019 SHALL, while rst=1, asynchronously force out_valid=0, all control/data/register outputs=0, bubble_cnt=0, skid entry invalid, in_ready=0.
REQ-020 SHALL present in_ready=1 in the first cycle after rst deasserts; reset mid-transfer discards all entries without counting them.

Configuration
REQ-021 SHALL, when macro ID_EX_SKID_EN is defined, add a one-entry skid buffer: in_ready = !flush && !skid_valid, taken from a register with no combinational path from out_ready.
REQ-022 SHALL, with ID_EX_SKID_EN, store an accepted entry in the skid when output is held (out_valid=1, out_ready=0); on release, the skid entry moves to output next cycle, preserving order; capacity two entries.
REQ-023 SHALL, with ID_EX_SKID_EN, count a flush killing output and skid entries as one increment.
REQ-024 SHALL, without ID_EX_SKID_EN, contain no skid storage and follow REQ-011.

Verification
REQ-025 SHALL cover: reset, then in_valid=1, ctlex_in=4'b1011, npc=32'h0000_0004, out_ready=1 -> next cycle out_valid=1, regdst=1, aluop=2'b01, alusrc=1, npcout=32'h4.
REQ-026 SHALL cover: out_ready=0 for 3 cycles with readdat1=32'hDEAD_BEEF loaded -> rdata1out stays DEAD_BEEF; no-skid in_ready=0; skid in_ready=1 once then 0.
REQ-027 SHALL cover: flush=1 with out_valid=1 and bubble_cnt=5 -> next cycle out_valid=0, wb_ctlout=0, m_ctlout=0, bubble_cnt=6; flush on empty stage leaves count 6.
REQ-028 SHALL cover: bubble_cnt preloaded by flushes to 16'hFFFF, another valid flush -> bubble_cnt remains 16'hFFFF.
REQ-029 SHALL cover: rst=1 asserted mid-cycle while out_valid=1 -> outputs 0 immediately without clk edge; after release in_ready=1, bubble_cnt=0.
REQ-030 SHALL cover: (skid) three back-to-back entries npc=8,12,16 with out_ready toggling 0/1 -> npcout sequence 8,12,16, none dropped or duplicated.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and a saturating bubble counter.
// Define ID_EX_SKID_EN to add a one-entry skid buffer that registers in_ready.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        ctlwb_in,
    input  logic [2:0]        ctlm_in,
    input  logic [3:0]        ctlex_in,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] readdat1,
    input  logic [DATA_W-1:0] readdat2,
    input  logic [DATA_W-1:0] signext_in,
    input  logic [REG_W-1:0]  instr_2016,
    input  logic [REG_W-1:0]  instr_1511,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic              regdst,
    output logic [1:0]        aluop,
    output logic              alusrc,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] rdata1out,
    output logic [DATA_W-1:0] rdata2out,
    output logic [DATA_W-1:0] s_extendout,
    output logic [REG_W-1:0]  instrout_2016,
    output logic [REG_W-1:0]  instrout_1511,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [1:0]        wb;
        logic [2:0]        m;
        logic [3:0]        ex;
        logic [DATA_W-1:0] npc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sext;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t           in_e, out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic             accept, rel, kill;

    assign in_e = '{ctlwb_in, ctlm_in, ctlex_in, npc, readdat1, readdat2, signext_in,
                    instr_2016, instr_1511};

`ifdef ID_EX_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    // Ready depends only on state, so out_ready never reaches in_ready.
    assign in_ready = !rst && !flush && !skid_valid_q;
    assign kill     = out_valid_q || skid_valid_q;
`else
    assign in_ready = !rst && !flush && (!out_valid_q || out_ready);
    assign kill     = out_valid_q;
`endif

    assign accept = in_valid && in_ready;
    assign rel    = out_valid_q && out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        bubble_d    = bubble_q;
`ifdef ID_EX_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
`ifdef ID_EX_SKID_EN
            skid_valid_d = 1'b0;
`endif
            if (kill && (bubble_q != '1)) begin
                bubble_d = bubble_q + 1'b1;
            end
        end else begin
`ifdef ID_EX_SKID_EN
            if (skid_valid_q) begin
                if (rel) begin
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (out_valid_q && !out_ready) begin
                    skid_d       = in_e;
                    skid_valid_d = 1'b1;
                end else begin
                    out_d       = in_e;
                    out_valid_d = 1'b1;
                end
            end else if (rel) begin
                out_valid_d = 1'b0;
            end
`else
            if (accept) begin
                out_d       = in_e;
                out_valid_d = 1'b1;
            end else if (rel) begin
                out_valid_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            bubble_q    <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            bubble_q    <= bubble_d;
        end
    end

`ifdef ID_EX_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`endif

    // Control fields read as a nop whenever no entry is present.
    assign wb_ctlout     = out_valid_q ? out_q.wb : 2'b00;
    assign m_ctlout      = out_valid_q ? out_q.m : 3'b000;
    assign regdst        = out_valid_q & out_q.ex[3];
    assign aluop         = out_valid_q ? out_q.ex[2:1] : 2'b00;
    assign alusrc        = out_valid_q & out_q.ex[0];
    assign out_valid     = out_valid_q;
    assign npcout        = out_q.npc;
    assign rdata1out     = out_q.rd1;
    assign rdata2out     = out_q.rd2;
    assign s_extendout   = out_q.sext;
    assign instrout_2016 = out_q.rt;
    assign instrout_1511 = out_q.rd;
    assign bubble_cnt    = bubble_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: vector table plus hand-written multi-cycle sequences.
// A second instance with a 4-bit counter exercises saturation in few cycles.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [1:0]  ctlwb_in = '0;
    logic [2:0]  ctlm_in = '0;
    logic [3:0]  ctlex_in = '0;
    logic [31:0] npc = '0, readdat1 = '0, readdat2, signext_in;
    logic [4:0]  instr_2016, instr_1511;

    logic        in_ready, out_valid, regdst, alusrc;
    logic [1:0]  wb_ctlout, aluop;
    logic [2:0]  m_ctlout;
    logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
    logic [4:0]  instrout_2016, instrout_1511;
    logic [15:0] bubble_cnt;

    logic        s_in_ready, s_out_valid, s_regdst, s_alusrc;
    logic [1:0]  s_wb, s_aluop;
    logic [2:0]  s_m;
    logic [31:0] s_npc, s_rd1, s_rd2, s_sext;
    logic [4:0]  s_rt, s_rd;
    logic [3:0]  s_bub;

    assign readdat2   = ~readdat1;
    assign signext_in = readdat1 + 32'd1;
    assign instr_2016 = readdat1[4:0];
    assign instr_1511 = readdat1[9:5];

    always #5 clk = ~clk;

    id_ex_pipe_reg u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in), .npc(npc),
        .readdat1(readdat1), .readdat2(readdat2), .signext_in(signext_in),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .out_valid(out_valid),
        .out_ready(out_ready), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .regdst(regdst),
        .aluop(aluop), .alusrc(alusrc), .npcout(npcout), .rdata1out(rdata1out),
        .rdata2out(rdata2out), .s_extendout(s_extendout), .instrout_2016(instrout_2016),
        .instrout_1511(instrout_1511), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .flush(flush),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in), .npc(npc),
        .readdat1(readdat1), .readdat2(readdat2), .signext_in(signext_in),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .out_valid(s_out_valid),
        .out_ready(out_ready), .wb_ctlout(s_wb), .m_ctlout(s_m), .regdst(s_regdst),
        .aluop(s_aluop), .alusrc(s_alusrc), .npcout(s_npc), .rdata1out(s_rd1),
        .rdata2out(s_rd2), .s_extendout(s_sext), .instrout_2016(s_rt),
        .instrout_1511(s_rd), .bubble_cnt(s_bub)
    );

`ifdef ID_EX_SKID_EN
    localparam logic HoldRdy = 1'b1;
`else
    localparam logic HoldRdy = 1'b0;
`endif

    typedef struct {
        logic        iv, ordy, fl;
        logic [3:0]  ex;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] npc, rd1;
        logic        e_rdy, e_ov;
        logic [3:0]  e_ex;
        logic [1:0]  e_wb;
        logic [2:0]  e_m;
        logic [31:0] e_npc, e_rd1;
        logic [15:0] e_bub;
    } vec_t;

    vec_t vt[12];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] n, input logic [31:0] r1);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        npc       = n;
        readdat1  = r1;
        ctlex_in  = 4'b1111;
        ctlwb_in  = 2'b11;
        ctlm_in   = 3'b111;
    endtask

    logic [31:0] exp_npc[3];
    int          idx, nout;
    logic        acc;

    initial begin
        vt[0]  = '{1, 1, 0, 4'b1011, 2'b10, 3'b101, 32'h4, 32'h11,
                   1, 1, 4'b1011, 2'b10, 3'b101, 32'h4, 32'h11, 16'd0};
        vt[1]  = '{1, 1, 0, 4'b0100, 2'b01, 3'b010, 32'h8, 32'hDEAD_BEEF,
                   1, 1, 4'b0100, 2'b01, 3'b010, 32'h8, 32'hDEAD_BEEF, 16'd0};
        vt[2]  = '{0, 0, 0, 4'b0, 2'b0, 3'b0, 32'h0, 32'h0,
                   HoldRdy, 1, 4'b0100, 2'b01, 3'b010, 32'h8, 32'hDEAD_BEEF, 16'd0};
        vt[3]  = vt[2];
        vt[4]  = vt[2];
        vt[5]  = '{0, 1, 0, 4'b0, 2'b0, 3'b0, 32'h0, 32'h0,
                   1, 0, 4'b0, 2'b0, 3'b0, 32'h8, 32'hDEAD_BEEF, 16'd0};
        vt[6]  = '{1, 0, 0, 4'b1111, 2'b11, 3'b111, 32'hC, 32'h22,
                   1, 1, 4'b1111, 2'b11, 3'b111, 32'hC, 32'h22, 16'd0};
        vt[7]  = '{1, 1, 1, 4'b0001, 2'b01, 3'b001, 32'h10, 32'h33,
                   0, 0, 4'b0, 2'b0, 3'b0, 32'hC, 32'h22, 16'd1};
        vt[8]  = '{0, 0, 1, 4'b0, 2'b0, 3'b0, 32'h0, 32'h0,
                   0, 0, 4'b0, 2'b0, 3'b0, 32'hC, 32'h22, 16'd1};
        vt[9]  = '{1, 1, 0, 4'b0010, 2'b00, 3'b001, 32'h14, 32'h44,
                   1, 1, 4'b0010, 2'b00, 3'b001, 32'h14, 32'h44, 16'd1};
        vt[10] = '{1, 1, 0, 4'b1000, 2'b10, 3'b000, 32'h18, 32'h55,
                   1, 1, 4'b1000, 2'b10, 3'b000, 32'h18, 32'h55, 16'd1};
        vt[11] = '{0, 1, 0, 4'b0, 2'b0, 3'b0, 32'h0, 32'h0,
                   1, 0, 4'b0, 2'b0, 3'b0, 32'h18, 32'h55, 16'd1};

        // Reset state, then first cycle after release.
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_npcout", npcout, 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        #10;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            in_valid  = vt[i].iv;
            out_ready = vt[i].ordy;
            flush     = vt[i].fl;
            ctlex_in  = vt[i].ex;
            ctlwb_in  = vt[i].wb;
            ctlm_in   = vt[i].m;
            npc       = vt[i].npc;
            readdat1  = vt[i].rd1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("v%0d_ctl", i),
                32'({wb_ctlout, m_ctlout, regdst, aluop, alusrc}),
                32'({vt[i].e_wb, vt[i].e_m, vt[i].e_ex}));
            chk($sformatf("v%0d_npcout", i), npcout, vt[i].e_npc);
            chk($sformatf("v%0d_rdata1out", i), rdata1out, vt[i].e_rd1);
            chk($sformatf("v%0d_rdata2out", i), rdata2out, ~vt[i].e_rd1);
            chk($sformatf("v%0d_sext", i), s_extendout, vt[i].e_rd1 + 32'd1);
            chk($sformatf("v%0d_instr", i), 32'({instrout_1511, instrout_2016}),
                32'(vt[i].e_rd1[9:0]));
            chk($sformatf("v%0d_bubble", i), 32'(bubble_cnt), 32'(vt[i].e_bub));
        end

        // Bring the bubble count to 5, then flush a live entry and an empty stage.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 32'(k), 32'h1);
            tick();
            drive(0, 0, 1, 32'h0, 32'h0);
            tick();
        end
        chk("bubble_at_5", 32'(bubble_cnt), 32'd5);
        drive(1, 0, 0, 32'h30, 32'h2);
        tick();
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        drive(1, 1, 1, 32'h34, 32'h3);
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_wb", 32'(wb_ctlout), 32'd0);
        chk("flush_m", 32'(m_ctlout), 32'd0);
        chk("flush_bubble_6", 32'(bubble_cnt), 32'd6);
        drive(0, 0, 1, 32'h0, 32'h0);
        tick();
        chk("empty_flush_bubble", 32'(bubble_cnt), 32'd6);

        // The 4-bit counter saturates at all-ones while the 16-bit one keeps counting.
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 32'h50, 32'h5);
            tick();
            drive(0, 0, 1, 32'h0, 32'h0);
            tick();
        end
        chk("sat_wide_16", 32'(bubble_cnt), 32'd16);
        chk("sat_narrow_f", 32'(s_bub), 32'hF);
        drive(1, 0, 0, 32'h54, 32'h6);
        tick();
        drive(0, 0, 1, 32'h0, 32'h0);
        tick();
        chk("sat_wide_17", 32'(bubble_cnt), 32'd17);
        chk("sat_narrow_hold", 32'(s_bub), 32'hF);

`ifdef ID_EX_SKID_EN
        // Skid takes exactly one entry behind a stalled output; a flush kills both as one.
        drive(1, 1, 0, 32'h20, 32'hDEAD_BEEF);
        tick();
        drive(1, 0, 0, 32'h24, 32'h7);
        #1;
        chk("skid_rdy_once", 32'(in_ready), 32'd1);
        tick();
        chk("skid_hold_rd1", rdata1out, 32'hDEAD_BEEF);
        drive(1, 0, 0, 32'h28, 32'h8);
        #1;
        chk("skid_rdy_full", 32'(in_ready), 32'd0);
        tick();
        chk("skid_hold_npc", npcout, 32'h20);
        drive(0, 0, 1, 32'h0, 32'h0);
        tick();
        chk("skid_flush_bubble", 32'(bubble_cnt), 32'd18);
        chk("skid_flush_valid", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("skid_cleared_rdy", 32'(in_ready), 32'd1);
`endif

        // Three back-to-back entries against a toggling out_ready must emerge in order once.
        drive(0, 0, 0, 32'h0, 32'h0);
        exp_npc[0] = 32'd8;
        exp_npc[1] = 32'd12;
        exp_npc[2] = 32'd16;
        idx  = 0;
        nout = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c % 2) == 1;
            in_valid  = idx < 3;
            npc       = (idx < 3) ? exp_npc[idx] : 32'h0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (nout < 3) begin
                    chk($sformatf("order_%0d", nout), npcout, exp_npc[nout]);
                end else begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL order_extra: got %h, want no further entry", npcout);
                end
                nout++;
            end
            tick();
            if (acc) idx++;
            if (idx == 3 && nout == 3) break;
        end
        chk("order_count", 32'(nout), 32'd3);
        drive(0, 1, 0, 32'h0, 32'h0);
        tick();
        chk("order_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle discards the held entry and the count.
        drive(1, 0, 0, 32'h40, 32'h9);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ctl", 32'({wb_ctlout, m_ctlout, regdst, aluop, alusrc}), 32'd0);
        chk("arst_npc", npcout, 32'd0);
        chk("arst_rd1", rdata1out, 32'd0);
        chk("arst_bubble", 32'(bubble_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        chk("after_rst_bubble", 32'(bubble_cnt), 32'd0);
        chk("after_rst_narrow", 32'(s_bub), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
